// File: rtl/fft_pkg.sv
// ============================================================================
// Module : fft_pkg
// Brief  : Shared types and elaboration-time helpers for the FFT frame engine.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package fft_pkg;

  localparam int TW_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    COMPUTE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned bitrev(input int unsigned value, input int unsigned bits);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if (i < int'(bits)) r = (r << 1) | ((value >> i) & 32'd1);
    end
    return r;
  endfunction

  // Twiddle W_k = cos(2pi k/n) - j sin(2pi k/n) in Q2.(tw_w-2), rounded to nearest.
  // Angles are taken on a 64-step circle and folded into the first quadrant so a
  // short Q30 Taylor series is accurate far beyond the output precision.
  function automatic int tw_value(input int k, input int n, input int tw_w, input bit imag);
    longint x, x2, term, c, s, v, half;
    int     m, mr, sh;
    bit     neg;
    m   = (k * 64) / n;
    mr  = m;
    neg = 1'b0;
    if (m > 16) begin
      mr  = 32 - m;
      neg = 1'b1;
    end
    x    = (64'sd3373259426 * longint'(mr)) / 64'sd32;
    x2   = (x * x) >>> 30;
    c    = 64'sd1 <<< 30;
    term = c;
    for (int i = 1; i <= 8; i++) begin
      term = -((term * x2) >>> 30) / longint'((2 * i - 1) * (2 * i));
      c    = c + term;
    end
    term = x;
    s    = x;
    for (int i = 1; i <= 8; i++) begin
      term = -((term * x2) >>> 30) / longint'((2 * i) * (2 * i + 1));
      s    = s + term;
    end
    if (neg) c = -c;
    v    = imag ? -s : c;
    sh   = 30 - (tw_w - 2);
    half = 64'sd1 <<< (sh - 1);
    return int'((v + half) >>> sh);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fft_butterfly.sv
// ============================================================================
// Module : fft_butterfly
// Brief  : Combinational radix-2 DIT butterfly; FFT_STAGE_SCALE_EN adds >>1.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fft_butterfly #(
  parameter int W    = 16,
  parameter int TW_W = 16
) (
  input  logic signed [W-1:0]    a_re,
  input  logic signed [W-1:0]    a_im,
  input  logic signed [W-1:0]    b_re,
  input  logic signed [W-1:0]    b_im,
  input  logic signed [TW_W-1:0] tw_re,
  input  logic signed [TW_W-1:0] tw_im,
  output logic signed [W-1:0]    x_re,
  output logic signed [W-1:0]    x_im,
  output logic signed [W-1:0]    y_re,
  output logic signed [W-1:0]    y_im
);

  localparam int c_pw = W + TW_W + 1;
  localparam int c_sh = TW_W - 2;
  localparam logic signed [c_pw-1:0] c_rnd = c_pw'(64'sd1 <<< (TW_W - 3));

  logic signed [c_pw-1:0] w_ar, w_ai, w_br, w_bi, w_wr, w_wi;
  logic signed [c_pw-1:0] w_tr, w_ti, w_xr, w_xi, w_yr, w_yi;

  assign w_ar = c_pw'(a_re);
  assign w_ai = c_pw'(a_im);
  assign w_br = c_pw'(b_re);
  assign w_bi = c_pw'(b_im);
  assign w_wr = c_pw'(tw_re);
  assign w_wi = c_pw'(tw_im);

  // Single rounding after the complex sum of products.
  assign w_tr = (w_br * w_wr - w_bi * w_wi + c_rnd) >>> c_sh;
  assign w_ti = (w_br * w_wi + w_bi * w_wr + c_rnd) >>> c_sh;

  assign w_xr = w_ar + w_tr;
  assign w_xi = w_ai + w_ti;
  assign w_yr = w_ar - w_tr;
  assign w_yi = w_ai - w_ti;

`ifdef FFT_STAGE_SCALE_EN
  assign x_re = W'(w_xr >>> 1);
  assign x_im = W'(w_xi >>> 1);
  assign y_re = W'(w_yr >>> 1);
  assign y_im = W'(w_yi >>> 1);
`else
  assign x_re = W'(w_xr);
  assign x_im = W'(w_xi);
  assign y_re = W'(w_yr);
  assign y_im = W'(w_yi);
`endif

endmodule

`default_nettype wire

// File: rtl/fft_frame_engine.sv
// ============================================================================
// Module : fft_frame_engine
// Brief  : Streaming N-point in-place radix-2 FFT, valid/ready in and out.
//          Optional per-stage scaling via FFT_STAGE_SCALE_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fft_frame_engine
  import fft_pkg::*;
#(
  parameter  int N_POINTS = 8,
  parameter  int IN_W     = 12,
  parameter  int OUT_W    = 12,
  parameter  int TW_W     = TW_W_DEFAULT,
  localparam int LOG2N    = clog2(N_POINTS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [IN_W-1:0]  s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [OUT_W-1:0] m_real,
  output logic [OUT_W-1:0] m_imag,
  output logic [LOG2N-1:0] m_index,
  output logic             m_last,
  output logic             busy
);

`ifdef FFT_STAGE_SCALE_EN
  localparam int c_w = IN_W + 2;
`else
  localparam int c_w = IN_W + LOG2N + 1;
`endif
  localparam int c_hw   = LOG2N - 1;
  localparam int c_half = N_POINTS / 2;
  localparam logic [LOG2N-1:0] c_last_idx   = LOG2N'(N_POINTS - 1);
  localparam logic [LOG2N-1:0] c_one        = LOG2N'(1);
  localparam logic [c_hw-1:0]  c_last_bfly  = c_hw'(c_half - 1);
  localparam logic [2:0]       c_last_stage = 3'(LOG2N - 1);

  state_t r_state, w_next;

  logic [LOG2N-1:0] r_cnt;
  logic [2:0]       r_stage;
  logic [c_hw-1:0]  r_bfly;

  logic signed [c_w-1:0]  r_re [N_POINTS];
  logic signed [c_w-1:0]  r_im [N_POINTS];
  logic signed [TW_W-1:0] w_tw_re [c_half];
  logic signed [TW_W-1:0] w_tw_im [c_half];

  logic [c_hw-1:0]   w_pos, w_grp, w_twi;
  logic [LOG2N-1:0]  w_a, w_b, w_fill_addr;
  logic signed [c_w-1:0] w_x_re, w_x_im, w_y_re, w_y_im;
  logic              w_bfly_last;

  for (genvar k = 0; k < c_half; k++) begin : g_tw
    localparam logic signed [TW_W-1:0] c_re = TW_W'(tw_value(k, N_POINTS, TW_W, 1'b0));
    localparam logic signed [TW_W-1:0] c_im = TW_W'(tw_value(k, N_POINTS, TW_W, 1'b1));
    assign w_tw_re[k] = c_re;
    assign w_tw_im[k] = c_im;
  end

  assign w_bfly_last = (r_stage == c_last_stage) && (r_bfly == c_last_bfly);
  assign w_fill_addr = LOG2N'(bitrev(32'(r_cnt), LOG2N));

  // Butterfly j of stage s pairs a = group*2^(s+1) + pos with b = a + 2^s.
  always_comb begin
    w_pos = r_bfly & c_hw'((1 << r_stage) - 1);
    w_grp = r_bfly >> r_stage;
    w_twi = c_hw'(w_pos << (c_hw - int'(r_stage)));
    w_a   = ({w_grp, 1'b0} << r_stage) | {1'b0, w_pos};
    w_b   = w_a | (c_one << r_stage);
  end

  fft_butterfly #(
    .W    (c_w),
    .TW_W (TW_W)
  ) u_bfly (
    .a_re  (r_re[w_a]),
    .a_im  (r_im[w_a]),
    .b_re  (r_re[w_b]),
    .b_im  (r_im[w_b]),
    .tw_re (w_tw_re[w_twi]),
    .tw_im (w_tw_im[w_twi]),
    .x_re  (w_x_re),
    .x_im  (w_x_im),
    .y_re  (w_y_re),
    .y_im  (w_y_im)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= FILL;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    s_ready = 1'b0;
    m_valid = 1'b0;
    busy    = 1'b0;
    unique case (r_state)
      FILL: begin
        s_ready = 1'b1;
        if (s_valid && (r_cnt == c_last_idx)) w_next = COMPUTE;
      end
      COMPUTE: begin
        busy = 1'b1;
        if (w_bfly_last) w_next = DRAIN;
      end
      DRAIN: begin
        m_valid = 1'b1;
        busy    = 1'b1;
        if (m_ready && (r_cnt == c_last_idx)) w_next = FILL;
      end
      default: w_next = FILL;
    endcase
  end

  // r_cnt and r_bfly wrap to zero on their final step, ready for the next phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_stage <= '0;
      r_bfly  <= '0;
    end else begin
      unique case (r_state)
        FILL:    if (s_valid) r_cnt <= r_cnt + c_one;
        COMPUTE: begin
          r_bfly <= r_bfly + c_hw'(1);
          if (r_bfly == c_last_bfly)
            r_stage <= (r_stage == c_last_stage) ? 3'd0 : r_stage + 3'd1;
        end
        DRAIN:   if (m_ready) r_cnt <= r_cnt + c_one;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if ((r_state == FILL) && s_valid) begin
      r_re[w_fill_addr] <= $signed({{(c_w - IN_W){1'b0}}, s_data});
      r_im[w_fill_addr] <= '0;
    end else if (r_state == COMPUTE) begin
      r_re[w_a] <= w_x_re;
      r_im[w_a] <= w_x_im;
      r_re[w_b] <= w_y_re;
      r_im[w_b] <= w_y_im;
    end
  end

  assign m_real  = m_valid ? r_re[r_cnt][c_w-1 -: OUT_W] : '0;
  assign m_imag  = m_valid ? r_im[r_cnt][c_w-1 -: OUT_W] : '0;
  assign m_index = m_valid ? r_cnt : '0;
  assign m_last  = m_valid && (r_cnt == c_last_idx);

endmodule

`default_nettype wire

// File: tb/tb_fft_frame_engine.sv
// ============================================================================
// Module : tb_fft_frame_engine
// Brief  : Self-checking bench for fft_frame_engine (N=8) against an integer FFT model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_fft_frame_engine;

  localparam int N = 8;
`ifdef FFT_STAGE_SCALE_EN
  localparam int W = 14;
`else
  localparam int W = 16;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [11:0] s_data = '0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [11:0] m_real, m_imag;
  logic [2:0]  m_index;
  logic        m_last;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int          frame [N];
  logic [11:0] exp_re [N];
  logic [11:0] exp_im [N];

  always #5 clk = ~clk;

  fft_frame_engine #(
    .N_POINTS (8),
    .IN_W     (12),
    .OUT_W    (12),
    .TW_W     (16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_real  (m_real),
    .m_imag  (m_imag),
    .m_index (m_index),
    .m_last  (m_last),
    .busy    (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int brev3(input int v);
    return ((v & 1) << 2) | (v & 2) | ((v >> 2) & 1);
  endfunction

  // Textbook decimation-in-time FFT with the engine's fixed-point rounding rules.
  task automatic model_frame();
    longint re [N];
    longint im [N];
    longint wr, wi, tr, ti, xr, xi, yr, yi;
    real    ang;
    for (int k = 0; k < N; k++) begin
      re[brev3(k)] = longint'(frame[k]);
      im[brev3(k)] = 0;
    end
    for (int half = 1; half < N; half = half * 2) begin
      for (int base = 0; base < N; base = base + 2 * half) begin
        for (int p = 0; p < half; p++) begin
          int a, b, e;
          a   = base + p;
          b   = a + half;
          e   = p * (N / (2 * half));
          ang = 2.0 * 3.14159265358979 * e / N;
          wr  = longint'($rtoi($floor($cos(ang) * 16384.0 + 0.5)));
          wi  = longint'($rtoi($floor(-$sin(ang) * 16384.0 + 0.5)));
          tr  = (re[b] * wr - im[b] * wi + 8192) >>> 14;
          ti  = (re[b] * wi + im[b] * wr + 8192) >>> 14;
          xr  = re[a] + tr;  xi = im[a] + ti;
          yr  = re[a] - tr;  yi = im[a] - ti;
`ifdef FFT_STAGE_SCALE_EN
          xr = xr >>> 1;  xi = xi >>> 1;  yr = yr >>> 1;  yi = yi >>> 1;
`endif
          re[a] = xr;  im[a] = xi;  re[b] = yr;  im[b] = yi;
        end
      end
    end
    for (int k = 0; k < N; k++) begin
      exp_re[k] = 12'(re[k] >>> (W - 12));
      exp_im[k] = 12'(im[k] >>> (W - 12));
    end
  endtask

  task automatic send_frame(input int n);
    int k = 0;
    int guard = 0;
    while (k < n && guard < 400) begin
      @(negedge clk);
      guard++;
      if ($urandom_range(0, 3) == 0) begin
        s_valid = 1'b0;
        s_data  = 12'($urandom);
      end else begin
        chk("s_ready_fill", 32'(s_ready), 1);
        s_valid = 1'b1;
        s_data  = 12'(frame[k]);
        k++;
      end
    end
    chk("fill_count", k, n);
  endtask

  task automatic run_compute();
    int cyc = 0;
    int guard = 0;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = 12'($urandom);
    chk("s_ready_drop", 32'(s_ready), 0);
    while (!m_valid && guard < 100) begin
      if (busy) cyc++;
      @(negedge clk);
      guard++;
    end
    chk("compute_cycles", cyc, 12);
  endtask

  task automatic drain(input int mode, input int nbins);
    int idx = 0;
    int guard = 0;
    while (idx < nbins && guard < 300) begin
      m_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
      chk("m_valid", 32'(m_valid), 1);
      chk("m_index", 32'(m_index), idx);
      chk("m_real", 32'(m_real), 32'(exp_re[idx]));
      chk("m_imag", 32'(m_imag), 32'(exp_im[idx]));
      chk("m_last", 32'(m_last), (idx == N - 1) ? 1 : 0);
      chk("s_ready_drain", 32'(s_ready), 0);
      if (m_ready) idx++;
      @(negedge clk);
      guard++;
    end
    m_ready = 1'b0;
    s_valid = 1'b0;
    chk("drain_count", idx, nbins);
    if (nbins == N) begin
      chk("post_m_valid", 32'(m_valid), 0);
      chk("post_s_ready", 32'(s_ready), 1);
      chk("post_busy", 32'(busy), 0);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_s_ready"}, 32'(s_ready), 1);
    chk({tag, "_m_valid"}, 32'(m_valid), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_m_last"}, 32'(m_last), 0);
    chk({tag, "_m_index"}, 32'(m_index), 0);
    chk({tag, "_m_real"}, 32'(m_real), 0);
    chk({tag, "_m_imag"}, 32'(m_imag), 0);
  endtask

  task automatic reset_pulse();
    rst     = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b0;
    #1;
    check_idle("rst_async");
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic random_frame(input int maxv);
    for (int k = 0; k < N; k++) frame[k] = $urandom_range(0, maxv);
    model_frame();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
    @(negedge clk);
    check_idle("after_reset");

    // Constant input: all energy in bin 0.
    for (int k = 0; k < N; k++) frame[k] = 100;
    for (int k = 0; k < N; k++) begin exp_re[k] = '0; exp_im[k] = '0; end
`ifdef FFT_STAGE_SCALE_EN
    exp_re[0] = 12'd25;
`else
    exp_re[0] = 12'd50;
`endif
    send_frame(N); run_compute(); drain(0, N);

    // Impulse: flat spectrum.
    for (int k = 0; k < N; k++) frame[k] = (k == 0) ? 2047 : 0;
`ifdef FFT_STAGE_SCALE_EN
    model_frame();
`else
    for (int k = 0; k < N; k++) begin exp_re[k] = 12'd127; exp_im[k] = '0; end
`endif
    send_frame(N); run_compute(); drain(0, N);

    // Alternating: bins 0 and N/2 only.
    for (int k = 0; k < N; k++) frame[k] = (k % 2 == 0) ? 2000 : 0;
`ifdef FFT_STAGE_SCALE_EN
    model_frame();
`else
    for (int k = 0; k < N; k++) begin exp_re[k] = '0; exp_im[k] = '0; end
    exp_re[0] = 12'd500;
    exp_re[4] = 12'd500;
`endif
    send_frame(N); run_compute(); drain(0, N);

    // Full-scale input.
    for (int k = 0; k < N; k++) frame[k] = 4095;
    model_frame();
    send_frame(N); run_compute(); drain(0, N);

    // Back-pressured drain, then the following frame.
    random_frame(4095);
    send_frame(N); run_compute(); drain(1, N);
    random_frame(4095);
    send_frame(N); run_compute(); drain(0, N);

    // Reset mid-fill, then a fresh frame.
    random_frame(4095);
    send_frame(5);
    @(negedge clk);
    reset_pulse();
    random_frame(4095);
    send_frame(N); run_compute(); drain(1, N);

    // Reset mid-drain, then a fresh frame.
    random_frame(4095);
    send_frame(N); run_compute(); drain(0, 3);
    reset_pulse();
    random_frame(4095);
    send_frame(N); run_compute(); drain(0, N);

    for (int f = 0; f < 4; f++) begin
      random_frame((f % 2 == 0) ? 4095 : 255);
      send_frame(N); run_compute(); drain(f % 2, N);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
